// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// ram_port_arbiter_pkg -- shared defaults, port indices and read-tag type for the RAM port arbiter.
// Revision 1.0
package ram_port_arbiter_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int DATA_W_DEF  = 32;
  localparam int BURST_CNT_W = 4;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_DISP = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

  localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, port: 1'b0};

  // A change of owner restarts the burst; staying with the owner counts up and saturates.
  function automatic logic [BURST_CNT_W-1:0] next_burst_cnt(
    input logic                   owner_changed,
    input logic [BURST_CNT_W-1:0] cnt,
    input logic [BURST_CNT_W-1:0] cnt_max
  );
    if (owner_changed) return BURST_CNT_W'(1);
    if (cnt >= cnt_max) return cnt_max;
    return cnt + BURST_CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_rd_tag_pipe.sv
`default_nettype none
// rd_tag_pipe -- RD_LATENCY-stage shift register of read tags, cleared asynchronously.
// Revision 1.0
module rd_tag_pipe
  import ram_port_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage [RD_LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        stage[i] <= RD_TAG_IDLE;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[RD_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ram_port_arbiter -- round-robin, burst-bounded sharing of a single-port RAM between two requesters.
// Revision 1.0. Optional grant/conflict counters are built when RAM_ARB_STATS_EN is defined.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_douta
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_p0_grants,
  output logic [15:0]       stat_p1_grants,
  output logic [15:0]       stat_conflicts
`endif
);

  localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_BURST);

  logic                   last_owner;
  logic [BURST_CNT_W-1:0] burst_cnt;
  logic                   gnt_any;
  logic                   gnt_port;
  logic                   hold_burst;
  rd_tag_t                tag_in;
  rd_tag_t                tag_out;

  // burst_cnt == 0 means the previous cycle was idle, so a tie falls to the other port.
  assign hold_burst = (burst_cnt != '0) && (burst_cnt < BURST_MAX);

  always_comb begin
    gnt_any  = 1'b0;
    gnt_port = PORT_CPU;
    if (!reset) begin
      if (p0_req && p1_req) begin
        gnt_any  = 1'b1;
        gnt_port = hold_burst ? last_owner : ~last_owner;
      end else if (p0_req) begin
        gnt_any  = 1'b1;
        gnt_port = PORT_CPU;
      end else if (p1_req) begin
        gnt_any  = 1'b1;
        gnt_port = PORT_DISP;
      end
    end
  end

  assign p0_gnt = gnt_any && (gnt_port == PORT_CPU);
  assign p1_gnt = gnt_any && (gnt_port == PORT_DISP);

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_dina = '0;
    if (gnt_any) begin
      if (gnt_port == PORT_DISP) begin
        ram_we   = p1_we;
        ram_addr = p1_addr;
        ram_dina = p1_wdata;
      end else begin
        ram_we   = p0_we;
        ram_addr = p0_addr;
        ram_dina = p0_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= PORT_DISP;
      burst_cnt  <= '0;
    end else if (gnt_any) begin
      last_owner <= gnt_port;
      burst_cnt  <= next_burst_cnt(gnt_port != last_owner, burst_cnt, BURST_MAX);
    end else begin
      burst_cnt  <= '0;
    end
  end

  assign tag_in.valid = gnt_any && !ram_we;
  assign tag_in.port  = gnt_port;

  rd_tag_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // The RAM itself returns douta; the tag only steers it to the issuing port.
  assign p0_rvalid = tag_out.valid && (tag_out.port == PORT_CPU);
  assign p1_rvalid = tag_out.valid && (tag_out.port == PORT_DISP);
  assign p0_rdata  = p0_rvalid ? ram_douta : '0;
  assign p1_rdata  = p1_rvalid ? ram_douta : '0;

`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_p0_grants <= '0;
      stat_p1_grants <= '0;
      stat_conflicts <= '0;
    end else begin
      if (p0_gnt) stat_p0_grants <= stat_p0_grants + 16'd1;
      if (p1_gnt) stat_p1_grants <= stat_p1_grants + 16'd1;
      if (p0_req && p1_req) stat_conflicts <= stat_conflicts + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// tb_ram_port_arbiter -- directed and randomized checks of ram_port_arbiter against a behavioural model.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

  localparam int AW     = 10;
  localparam int DW     = 32;
  localparam int RD_LAT = 1;
  localparam int MAXB   = 4;
  localparam int DEPTH  = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dina, ram_douta;
`ifdef RAM_ARB_STATS_EN
  logic [15:0]   stat_p0_grants, stat_p1_grants, stat_conflicts;
`endif

  ram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RD_LAT), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .reset(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_dina(ram_dina), .ram_douta(ram_douta)
`ifdef RAM_ARB_STATS_EN
    , .stat_p0_grants(stat_p0_grants), .stat_p1_grants(stat_p1_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 5) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  // Write-first single-port RAM with RD_LAT cycles of read latency.
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] ram_rd  [RD_LAT];
  assign ram_douta = ram_rd[RD_LAT-1];

  initial begin
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = init_word(i);
    for (int i = 0; i < RD_LAT; i++) ram_rd[i] = '0;
    forever begin
      @(posedge clk);
      for (int i = RD_LAT - 1; i > 0; i--) ram_rd[i] = ram_rd[i-1];
      if (ram_we) begin
        ram_mem[ram_addr] = ram_dina;
        ram_rd[0] = ram_dina;
      end else begin
        ram_rd[0] = ram_mem[ram_addr];
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: memory contents, a queue of pending read returns and the arbitration history.
  typedef struct {
    int            due;
    logic          port;
    logic [DW-1:0] data;
  } ret_t;

  logic [DW-1:0] ref_mem [DEPTH];
  ret_t          ret_q [$];
  logic          m_owner;
  int            m_run;
  logic          exp_g0, exp_g1;
  logic [15:0]   m_p0g, m_p1g, m_conf;

  task automatic model_step();
    logic          g_any, g_port, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_rd0, e_rd1;
    logic [1:0]    e_rv;
    ret_t          r;
    cyc++;
    g_any  = 1'b0;
    g_port = 1'b0;
    if (!rst) begin
      if (p0_req && p1_req) begin
        g_any  = 1'b1;
        g_port = (m_run > 0 && m_run < MAXB) ? m_owner : !m_owner;
      end else if (p0_req) begin
        g_any = 1'b1;
      end else if (p1_req) begin
        g_any  = 1'b1;
        g_port = 1'b1;
      end
    end
    e_we   = g_any && (g_port ? p1_we : p0_we);
    e_addr = !g_any ? '0 : (g_port ? p1_addr : p0_addr);
    e_din  = !g_any ? '0 : (g_port ? p1_wdata : p0_wdata);
    exp_g0 = g_any && !g_port;
    exp_g1 = g_any && g_port;
    check_eq("gnt", 64'({p1_gnt, p0_gnt}), 64'({exp_g1, exp_g0}));
    check_eq("ram_bus", 64'({ram_we, ram_addr, ram_dina}), 64'({e_we, e_addr, e_din}));

    e_rv  = 2'b00;
    e_rd0 = '0;
    e_rd1 = '0;
    if (rst) begin
      ret_q.delete();
    end else if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      r = ret_q.pop_front();
      if (r.port) begin
        e_rv[1] = 1'b1;
        e_rd1   = r.data;
      end else begin
        e_rv[0] = 1'b1;
        e_rd0   = r.data;
      end
    end
    check_eq("rvalid", 64'({p1_rvalid, p0_rvalid}), 64'(e_rv));
    check_eq("p0_rdata", 64'(p0_rdata), 64'(e_rd0));
    check_eq("p1_rdata", 64'(p1_rdata), 64'(e_rd1));

    if (rst) begin
      m_p0g = '0;
      m_p1g = '0;
      m_conf = '0;
    end
`ifdef RAM_ARB_STATS_EN
    check_eq("stat_p0", 64'(stat_p0_grants), 64'(m_p0g));
    check_eq("stat_p1", 64'(stat_p1_grants), 64'(m_p1g));
    check_eq("stat_conf", 64'(stat_conflicts), 64'(m_conf));
`endif

    if (rst) begin
      m_owner = 1'b1;
      m_run   = 0;
    end else begin
      if (p0_req && p1_req) m_conf++;
      if (g_any) begin
        if (e_we) begin
          ref_mem[e_addr] = e_din;
        end else begin
          r.due  = cyc + RD_LAT;
          r.port = g_port;
          r.data = ref_mem[e_addr];
          ret_q.push_back(r);
        end
        if (g_port == m_owner && m_run > 0) m_run = (m_run < MAXB) ? m_run + 1 : MAXB;
        else m_run = 1;
        m_owner = g_port;
        if (g_port) m_p1g++;
        else m_p0g++;
      end else begin
        m_run = 0;
      end
    end
  endtask

  logic          nx_rst, nx_r0, nx_we0, nx_r1, nx_we1;
  logic [AW-1:0] nx_a0, nx_a1;
  logic [DW-1:0] nx_d0, nx_d1;

  // Inputs change just after the active edge; outputs are judged on the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    rst = nx_rst;
    p0_req = nx_r0; p0_we = nx_we0; p0_addr = nx_a0; p0_wdata = nx_d0;
    p1_req = nx_r1; p1_we = nx_we1; p1_addr = nx_a1; p1_wdata = nx_d1;
    @(negedge clk);
    model_step();
  endtask

  task automatic idle_inputs();
    nx_r0 = 1'b0; nx_we0 = 1'b0; nx_a0 = '0; nx_d0 = '0;
    nx_r1 = 1'b0; nx_we1 = 1'b0; nx_a1 = '0; nx_d1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nx_rst = 1'b1;
    cycle();
    nx_rst = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 15));
    return AW'($urandom);
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    m_owner = 1'b1; m_run = 0; m_p0g = '0; m_p1g = '0; m_conf = '0;
    rst = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    idle_inputs();

    // Outputs stay quiet during reset even with both ports requesting.
    nx_rst = 1'b1; nx_r0 = 1'b1; nx_r1 = 1'b1; nx_we1 = 1'b1; nx_a1 = 10'h2A; nx_d1 = 32'hFFFF_0000;
    cycle();
    check_eq("rst_outputs", 64'({p0_gnt, p1_gnt, ram_we, ram_addr, ram_dina, p0_rvalid, p1_rvalid}), 64'd0);
    do_reset();

    // Single read from port 0.
    nx_r0 = 1'b1; nx_a0 = 10'h005;
    cycle();
    check_eq("t1_p0_gnt", 64'(p0_gnt), 64'd1);
    nx_r0 = 1'b0;
    cycle();
    check_eq("t1_p0_rvalid", 64'(p0_rvalid), 64'd1);
    check_eq("t1_p0_rdata", 64'(p0_rdata), 64'hDEADBEEF);
    check_eq("t1_p1_rvalid", 64'(p1_rvalid), 64'd0);

    // First tie after reset goes to port 0, returns stay in order.
    do_reset();
    nx_r0 = 1'b1; nx_a0 = 10'd1; nx_r1 = 1'b1; nx_a1 = 10'd2;
    cycle();
    check_eq("t2_first_gnt", 64'({p1_gnt, p0_gnt}), 64'b01);
    nx_r0 = 1'b0;
    cycle();
    check_eq("t2_second_gnt", 64'({p1_gnt, p0_gnt}), 64'b10);
    check_eq("t2_p0_ret", 64'({p0_rvalid, p0_rdata}), {31'd0, 1'b1, init_word(1)});
    nx_r1 = 1'b0;
    cycle();
    check_eq("t2_p1_ret", 64'({p1_rvalid, p1_rdata}), {31'd0, 1'b1, init_word(2)});

    // Burst limit: port 0 keeps four grants, then yields once.
    do_reset();
    nx_r1 = 1'b1; nx_a1 = 10'h100;
    for (int i = 0; i < 6; i++) begin
      nx_r0 = 1'b1; nx_a0 = AW'(i + 16);
      cycle();
      check_eq("t3_p0_gnt", 64'(p0_gnt), 64'(i != 4));
      check_eq("t3_p1_gnt", 64'(p1_gnt), 64'(i == 4));
      if (p1_gnt) nx_r1 = 1'b0;
    end
    idle_inputs();
    cycle();

    // Write from port 1 followed by read of the same word from port 0.
    nx_r1 = 1'b1; nx_we1 = 1'b1; nx_a1 = 10'h3FF; nx_d1 = 32'h12345678;
    cycle();
    check_eq("t4_we_n", 64'({ram_we, p1_gnt}), 64'b11);
    idle_inputs();
    nx_r0 = 1'b1; nx_a0 = 10'h3FF;
    cycle();
    check_eq("t4_we_n1", 64'({ram_we, p0_gnt}), 64'b01);
    nx_r0 = 1'b0;
    cycle();
    check_eq("t4_raw", 64'({p0_rvalid, p0_rdata}), {31'd0, 1'b1, 32'h12345678});

    // Reset right after a port 1 read grant discards the return.
    nx_r1 = 1'b1; nx_a1 = 10'd7;
    cycle();
    check_eq("t5_p1_gnt", 64'(p1_gnt), 64'd1);
    nx_rst = 1'b1; nx_r0 = 1'b1; nx_a0 = 10'd9;
    cycle();
    check_eq("t5_rst_out", 64'({p0_gnt, p1_gnt, ram_we, ram_addr, ram_dina, p0_rvalid, p1_rvalid}), 64'd0);
    cycle();
    nx_rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("t5_no_rvalid", 64'(p1_rvalid), 64'd0);
    end

`ifdef RAM_ARB_STATS_EN
    do_reset();
    nx_r0 = 1'b1; nx_a0 = 10'd3; nx_r1 = 1'b1; nx_a1 = 10'd4;
    repeat (10) cycle();
    idle_inputs();
    cycle();
    check_eq("t6_conflicts", 64'(stat_conflicts), 64'd10);
    check_eq("t6_grant_sum", 64'(stat_p0_grants + stat_p1_grants), 64'd10);
`endif

    // Randomized traffic with occasional resets; a waiting request is held unchanged.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (nx_rst) nx_rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) nx_rst = 1'b1;
      if (!nx_r0 || exp_g0) begin
        nx_r0 = ($urandom_range(0, 99) < 65); nx_we0 = ($urandom_range(0, 3) == 0);
        nx_a0 = rand_addr(); nx_d0 = $urandom;
      end
      if (!nx_r1 || exp_g1) begin
        nx_r1 = ($urandom_range(0, 99) < 65); nx_we1 = ($urandom_range(0, 3) == 0);
        nx_a1 = rand_addr(); nx_d1 = $urandom;
      end
      cycle();
    end
    idle_inputs();
    repeat (RD_LAT + 2) cycle();
    check_eq("drain_empty", 64'(ret_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
